pcie_hcmd_sq_fifo_rd: RTL and testbench



---
 rtl/pcie_hcmd_sq_fifo_rd_pkg.sv | 23 ++
 rtl/pcie_hcmd_skid_buf2.sv | 63 ++++++
 rtl/pcie_hcmd_sq_fifo_rd.sv | 69 ++++++
 tb/tb_pcie_hcmd_sq_fifo_rd.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_hcmd_sq_fifo_rd_pkg.sv
// Shared definitions for the host-command SQ FIFO read path: entry field offsets
// and the output buffer state encoding.
package pcie_hcmd_sq_fifo_rd_pkg;

  localparam int unsigned LP_SQ_HEAD_LSB  = 0;
  localparam int unsigned LP_SQ_HEAD_W    = 8;
  localparam int unsigned LP_SQ_QID_LSB   = 8;
  localparam int unsigned LP_SQ_QID_W     = 4;
  localparam int unsigned LP_SLOT_TAG_LSB = 12;

  // One-hot, same style as the SQ FIFO sync FSM.
  typedef enum logic [2:0] {
    StEmpty = 3'b001,
    StOne   = 3'b010,
    StFull2 = 3'b100
  } buf_state_e;

  function automatic logic qid_illegal(input logic [LP_SQ_QID_W-1:0] qid,
                                       input int unsigned num_sq);
    return 32'(qid) >= num_sq;
  endfunction

endpackage

// File: rtl/pcie_hcmd_skid_buf2.sv
// Generic 2-entry valid/ready buffer. Slot 0 drives the output, slot 1 is the
// skid slot. The producer must not push while o_full is high.
module pcie_hcmd_skid_buf2
  import pcie_hcmd_sq_fifo_rd_pkg::*;
#(
  parameter int unsigned P_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [P_WIDTH-1:0] i_push_data,
  output logic               o_full,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_WIDTH-1:0] o_data
);

  buf_state_e         r_state;
  logic [P_WIDTH-1:0] r_slot0;
  logic [P_WIDTH-1:0] r_slot1;
  logic               w_accept;

  assign w_accept = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StEmpty;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (i_push) begin
            r_slot0 <= i_push_data;
            r_state <= StOne;
          end
        end
        StOne: begin
          if (i_push && w_accept) begin
            r_slot0 <= i_push_data;
          end else if (i_push) begin
            r_slot1 <= i_push_data;
            r_state <= StFull2;
          end else if (w_accept) begin
            r_state <= StEmpty;
          end
        end
        StFull2: begin
          if (i_ready) begin
            r_slot0 <= r_slot1;
            r_state <= StOne;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign o_valid = (r_state != StEmpty);
  assign o_full  = (r_state == StFull2);
  assign o_data  = r_slot0;

endmodule

// File: rtl/pcie_hcmd_sq_fifo_rd.sv
// Host-command SQ FIFO reader: pops FWFT entries into a 2-entry buffer, splits
// them into command fields, and tracks a pop counter and a sticky bad-qid flag.
module pcie_hcmd_sq_fifo_rd
  import pcie_hcmd_sq_fifo_rd_pkg::*;
#(
  parameter int unsigned P_SLOT_TAG_WIDTH  = 10,
  parameter int unsigned P_FIFO_DATA_WIDTH = P_SLOT_TAG_WIDTH + 12,
  parameter int unsigned P_NUM_SQ          = 9
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst_n,
  input  logic                         fifo_empty_n,
  output logic                         fifo_rd_en,
  input  logic [P_FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                         rd_pause,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [P_SLOT_TAG_WIDTH-1:0]  cmd_slot_tag,
  output logic [3:0]                   cmd_sq_qid,
  output logic [7:0]                   cmd_sq_head,
  output logic [15:0]                  pop_cnt,
  output logic                         qid_err,
  output logic                         busy
);

  logic                         w_rd_en;
  logic                         w_full;
  logic [P_FIFO_DATA_WIDTH-1:0] w_entry;
  logic [15:0]                  r_pop_cnt;
  logic                         r_qid_err;

  // Reset gates the pop so the shared FIFO never loses an entry while we are held.
  assign w_rd_en    = pcie_user_rst_n & fifo_empty_n & ~rd_pause & ~w_full;
  assign fifo_rd_en = w_rd_en;

  pcie_hcmd_skid_buf2 #(
    .P_WIDTH (P_FIFO_DATA_WIDTH)
  ) u_skid_buf (
    .i_clk       (pcie_user_clk),
    .i_rst_n     (pcie_user_rst_n),
    .i_push      (w_rd_en),
    .i_push_data (fifo_rd_data),
    .o_full      (w_full),
    .o_valid     (cmd_valid),
    .i_ready     (cmd_ready),
    .o_data      (w_entry)
  );

  assign cmd_slot_tag = w_entry[P_FIFO_DATA_WIDTH-1:LP_SLOT_TAG_LSB];
  assign cmd_sq_qid   = w_entry[LP_SQ_QID_LSB +: LP_SQ_QID_W];
  assign cmd_sq_head  = w_entry[LP_SQ_HEAD_LSB +: LP_SQ_HEAD_W];

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      r_pop_cnt <= '0;
      r_qid_err <= 1'b0;
    end else if (w_rd_en) begin
      r_pop_cnt <= r_pop_cnt + 16'd1;
      if (qid_illegal(fifo_rd_data[LP_SQ_QID_LSB +: LP_SQ_QID_W], P_NUM_SQ)) begin
        r_qid_err <= 1'b1;
      end
    end
  end

  assign pop_cnt = r_pop_cnt;
  assign qid_err = r_qid_err;
  assign busy    = cmd_valid | w_rd_en;

endmodule

// File: tb/tb_pcie_hcmd_sq_fifo_rd.sv
// Randomised scoreboard bench for pcie_hcmd_sq_fifo_rd with a queue-based FIFO
// model and an occupancy-count reference for pop control.
module tb_pcie_hcmd_sq_fifo_rd;

  localparam int NUM_SQ = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty_n = 1'b0;
  logic [21:0] fifo_rd_data = '0;
  logic        rd_pause = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        fifo_rd_en;
  logic        cmd_valid;
  logic [9:0]  cmd_slot_tag;
  logic [3:0]  cmd_sq_qid;
  logic [7:0]  cmd_sq_head;
  logic [15:0] pop_cnt;
  logic        qid_err;
  logic        busy;

  pcie_hcmd_sq_fifo_rd dut (
    .pcie_user_clk   (clk),
    .pcie_user_rst_n (rst_n),
    .fifo_empty_n    (fifo_empty_n),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_rd_data    (fifo_rd_data),
    .rd_pause        (rd_pause),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_slot_tag    (cmd_slot_tag),
    .cmd_sq_qid      (cmd_sq_qid),
    .cmd_sq_head     (cmd_sq_head),
    .pop_cnt         (pop_cnt),
    .qid_err         (qid_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  logic [21:0] fifo_q[$];
  logic [21:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  int          n_acc = 0;
  logic [15:0] m_cnt = '0;
  bit          m_qerr = 0;
  bit          pop_pend = 0;
  bit          ready_v = 0;
  bit          pause_v = 0;
  int          last_qid = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Negedge: retire the head popped at the last edge, then drive the inputs.
  task automatic pre();
    @(negedge clk);
    if (pop_pend) fifo_q.delete(0);
    pop_pend     = 0;
    fifo_empty_n = (fifo_q.size() != 0);
    fifo_rd_data = fifo_empty_n ? fifo_q[0] : '0;
    cmd_ready    = ready_v;
    rd_pause     = pause_v;
  endtask

  // Just before the posedge: check against the occupancy model and log any pop.
  task automatic post();
    int occ;
    bit exp_rd;
    logic [21:0] e;
    #3;
    occ    = n_pop - n_acc;
    exp_rd = fifo_empty_n && !rd_pause && (occ < 2);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("cmd_valid", cmd_valid, occ != 0);
    chk("busy", busy, (occ != 0) || exp_rd);
    chk("pop_cnt", pop_cnt, m_cnt);
    chk("qid_err", qid_err, m_qerr);
    if (fifo_rd_en && fifo_empty_n) begin
      e = fifo_q[0];
      exp_q.push_back(e);
      n_pop++;
      m_cnt++;
      if (int'((e >> 8) & 22'hF) >= NUM_SQ) m_qerr = 1;
      pop_pend = 1;
    end
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic apply_reset();
    pre();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_tag", cmd_slot_tag, 0);
    chk("rst_qid", cmd_sq_qid, 0);
    chk("rst_head", cmd_sq_head, 0);
    chk("rst_cnt", pop_cnt, 0);
    chk("rst_qerr", qid_err, 0);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    n_pop  = 0;
    n_acc  = 0;
    m_cnt  = '0;
    m_qerr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post();
  endtask

  task automatic drain(input int max);
    int k = 0;
    pause_v = 0;
    ready_v = 1;
    while ((fifo_q.size() != 0 || n_pop != n_acc) && k < max) begin
      cycle();
      k++;
    end
    chk("drain_in_time", k < max, 1);
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && cmd_valid && cmd_ready) begin
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_tag", cmd_slot_tag, 32'(e >> 12));
          chk("beat_qid", cmd_sq_qid, 32'((e >> 8) & 22'hF));
          chk("beat_head", cmd_sq_head, 32'(e & 22'hFF));
        end
        last_qid = int'(cmd_sq_qid);
        n_acc++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, maxrun, run, k, pushed;

    apply_reset();

    // Backpressure: 3 queued, ready low -> exactly 2 pops.
    ready_v = 0;
    fifo_q.push_back(22'h12_3_45);
    fifo_q.push_back(22'h2A_1_10);
    fifo_q.push_back(22'h3C_5_20);
    b0 = n_pop;
    repeat (6) cycle();
    chk("bp_pops", n_pop - b0, 2);
    chk("bp_fifo_left", fifo_q.size(), 1);
    chk("bp_rd_en_low", fifo_rd_en, 0);
    ready_v = 1;
    cycle();
    cycle();
    chk("bp_third_pop", fifo_rd_en, 1);
    drain(20);

    // Reset with the buffer full and the FIFO still holding an entry.
    ready_v = 0;
    fifo_q.push_back(22'h111_2_01);
    fifo_q.push_back(22'h222_4_02);
    fifo_q.push_back(22'h0A5_3_07);
    repeat (4) cycle();
    chk("full2_held", busy, 0 + cmd_valid);
    apply_reset();
    ready_v = 1;
    k = 0;
    while (!cmd_valid && k < 10) begin
      cycle();
      k++;
    end
    chk("post_rst_valid", cmd_valid, 1);
    chk("post_rst_tag", cmd_slot_tag, 10'h0A5);
    chk("post_rst_qid", cmd_sq_qid, 3);
    chk("post_rst_head", cmd_sq_head, 8'h07);
    drain(20);

    // Streaming: 16 back-to-back entries.
    ready_v = 1;
    for (int i = 0; i < 16; i++) fifo_q.push_back({10'(i * 37), 4'(i % NUM_SQ), 8'(i + 1)});
    b0 = n_pop;
    maxrun = 0;
    run = 0;
    repeat (22) begin
      cycle();
      run = fifo_rd_en ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("stream_run", maxrun, 16);
    chk("stream_pops", n_pop - b0, 16);
    drain(20);

    // Pause: nothing popped, buffer idle; resumes the cycle after release.
    pause_v = 1;
    for (int i = 0; i < 4; i++) fifo_q.push_back({10'(i), 4'd1, 8'(i)});
    b0 = n_pop;
    repeat (6) cycle();
    chk("pause_no_pop", n_pop - b0, 0);
    chk("pause_busy", busy, 0);
    pause_v = 0;
    cycle();
    chk("pause_resume", fifo_rd_en, 1);
    drain(20);

    // Bad qid: flagged the next cycle, sticky, entry forwarded unchanged.
    fifo_q.push_back(22'h155_9_5A);
    drain(20);
    repeat (3) cycle();
    chk("bad_qid_flag", qid_err, 1);
    chk("bad_qid_fwd", last_qid, 9);

    // Random traffic.
    repeat (400) begin
      ready_v = ($urandom_range(0, 3) != 0);
      pause_v = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0) fifo_q.push_back(22'($urandom));
      cycle();
    end
    drain(300);

    // Counter wrap after 65536 pops.
    apply_reset();
    ready_v = 1;
    pause_v = 0;
    pushed = 0;
    k = 0;
    while (n_pop < 65536 && k < 70000) begin
      if (pushed < 65536 && fifo_q.size() < 4) begin
        fifo_q.push_back({10'(pushed), 4'd0, 8'(pushed)});
        pushed++;
      end
      cycle();
      k++;
    end
    drain(20);
    chk("wrap_pops", n_pop, 65536);
    chk("wrap_cnt", pop_cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
